// File: rtl/riscv_test_ctrl.sv
// riscv_test_ctrl: test-harness controller for a RISC-V core.
// It holds the core in reset for RST_CYCLES after release, then counts run cycles
// and watches for a tohost status write, a timeout or, optionally, a stalled PC.
// Optional halt detection is enabled with macro RISCV_TEST_CTRL_HALT_DET_EN.
//
//   state    | meaning
//   ---------+-----------------------------------------------
//   RST_HOLD | core held in reset, counting hold cycles
//   RUN      | core running, cycle counter advancing
//   PASS     | tohost reported 1 (sticky)
//   FAIL     | tohost reported odd code != 1 (sticky)
//   TIMEOUT  | run-cycle budget exhausted (sticky)
//   HALT     | PC stable for HALT_CYCLES cycles (sticky)
module riscv_test_ctrl #(
  parameter int              XLEN        = 32,
  parameter int              RST_CYCLES  = 4,
  parameter int              MAX_CYCLES  = 100,
  parameter logic [XLEN-1:0] TOHOST_ADDR = 32'h0000_0F00,
  parameter int              HALT_CYCLES = 8,
  parameter int              CNT_W       = 32
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic [XLEN-1:0]   i_pc,
  input  logic [XLEN-1:0]   i_dmem_addr,
  input  logic              i_dmem_wr_en,
  input  logic [XLEN-1:0]   i_dmem_wr_data,
  input  logic [XLEN/8-1:0] i_dmem_byte_sel,
  output logic              o_core_rstn,
  output logic              o_done,
  output logic              o_pass,
  output logic              o_fail,
  output logic              o_timeout,
  output logic              o_halt,
  output logic [XLEN-2:0]   o_exit_code,
  output logic [CNT_W-1:0]  o_cycle_cnt
);

  typedef enum logic [2:0] {
    RST_HOLD,
    RUN,
    PASS,
    FAIL,
    TIMEOUT,
    HALT
  } state_t;

  // RST_CYCLES of 0 or 1 both leave hold on the first edge after release.
  localparam int RW       = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int RST_LAST = (RST_CYCLES > 1) ? RST_CYCLES - 1 : 0;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(MAX_CYCLES - 1);

  state_t          state, state_next;
  logic [RW-1:0]   rst_cnt;
  logic            rst_done;
  logic            hit, pass_ev, fail_ev, halt_ev, timeout_ev;

  assign rst_done   = (rst_cnt == RST_LAST[RW-1:0]);
  assign hit        = i_dmem_wr_en && (i_dmem_addr == TOHOST_ADDR) && (&i_dmem_byte_sel);
  assign pass_ev    = hit && (i_dmem_wr_data == XLEN'(1));
  assign fail_ev    = hit && i_dmem_wr_data[0] && (i_dmem_wr_data[XLEN-1:1] != '0);
  assign timeout_ev = (o_cycle_cnt == TO_LAST);

`ifdef RISCV_TEST_CTRL_HALT_DET_EN
  localparam int HW        = $clog2(HALT_CYCLES + 1);
  localparam int HALT_LAST = (HALT_CYCLES > 1) ? HALT_CYCLES - 1 : 0;

  logic [XLEN-1:0] prev_pc;
  logic [HW-1:0]   stable_cnt;

  assign halt_ev = (i_pc == prev_pc) && (stable_cnt == HALT_LAST[HW-1:0]);

  // Track how many consecutive RUN cycles the PC has not moved.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      prev_pc    <= '0;
      stable_cnt <= '0;
    end else if (state == RUN) begin
      prev_pc    <= i_pc;
      stable_cnt <= (i_pc == prev_pc) ? stable_cnt + 1'b1 : '0;
    end
  end
`else
  logic unused_pc;
  assign unused_pc = ^i_pc;
  assign halt_ev   = 1'b0;
`endif

  // Next-state: tohost beats halt, halt beats timeout.
  always_comb begin
    state_next = state;
    case (state)
      RST_HOLD: if (rst_done) state_next = RUN;
      RUN: begin
        if (pass_ev)         state_next = PASS;
        else if (fail_ev)    state_next = FAIL;
        else if (halt_ev)    state_next = HALT;
        else if (timeout_ev) state_next = TIMEOUT;
      end
      default: state_next = state;
    endcase
  end

  // State, hold counter, run counter and registered outputs.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state       <= RST_HOLD;
      rst_cnt     <= '0;
      o_core_rstn <= 1'b0;
      o_done      <= 1'b0;
      o_pass      <= 1'b0;
      o_fail      <= 1'b0;
      o_timeout   <= 1'b0;
      o_halt      <= 1'b0;
      o_exit_code <= '0;
      o_cycle_cnt <= '0;
    end else begin
      state       <= state_next;
      o_core_rstn <= (state_next != RST_HOLD);
      o_pass      <= (state_next == PASS);
      o_fail      <= (state_next == FAIL);
      o_timeout   <= (state_next == TIMEOUT);
      o_halt      <= (state_next == HALT);
      o_done      <= (state_next == PASS) || (state_next == FAIL) ||
                     (state_next == TIMEOUT) || (state_next == HALT);
      if (state == RST_HOLD && !rst_done)
        rst_cnt <= rst_cnt + 1'b1;
      if (state == RUN && o_cycle_cnt != '1)
        o_cycle_cnt <= o_cycle_cnt + 1'b1;
      if (state == RUN && state_next == FAIL)
        o_exit_code <= i_dmem_wr_data[XLEN-1:1];
    end
  end

endmodule

// File: tb/tb_riscv_test_ctrl.sv
// Directed bench for riscv_test_ctrl with default parameters.
// Halt expectations follow RISCV_TEST_CTRL_HALT_DET_EN when the bench is built.
module tb_riscv_test_ctrl;

  logic        i_clk = 1'b0;
  logic        i_rstn = 1'b0;
  logic [31:0] i_pc = '0;
  logic [31:0] i_dmem_addr = '0;
  logic        i_dmem_wr_en = 1'b0;
  logic [31:0] i_dmem_wr_data = '0;
  logic [3:0]  i_dmem_byte_sel = '0;
  logic        o_core_rstn, o_done, o_pass, o_fail, o_timeout, o_halt;
  logic [30:0] o_exit_code;
  logic [31:0] o_cycle_cnt;

  int   checks = 0;
  int   errors = 0;
  logic hold_pc = 1'b0;

  riscv_test_ctrl dut (
    .i_clk          (i_clk),
    .i_rstn         (i_rstn),
    .i_pc           (i_pc),
    .i_dmem_addr    (i_dmem_addr),
    .i_dmem_wr_en   (i_dmem_wr_en),
    .i_dmem_wr_data (i_dmem_wr_data),
    .i_dmem_byte_sel(i_dmem_byte_sel),
    .o_core_rstn    (o_core_rstn),
    .o_done         (o_done),
    .o_pass         (o_pass),
    .o_fail         (o_fail),
    .o_timeout      (o_timeout),
    .o_halt         (o_halt),
    .o_exit_code    (o_exit_code),
    .o_cycle_cnt    (o_cycle_cnt)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock edge; outputs sampled 1ns later, then the PC moves on.
  task automatic step();
    @(posedge i_clk);
    #1;
    if (!hold_pc) i_pc = i_pc + 32'd4;
  endtask

  task automatic bus(input logic en, input logic [31:0] addr, input logic [31:0] data,
                     input logic [3:0] sel);
    i_dmem_wr_en    = en;
    i_dmem_addr     = addr;
    i_dmem_wr_data  = data;
    i_dmem_byte_sel = sel;
  endtask

  task automatic do_reset();
    i_rstn = 1'b0;
    #3;
    chk("rst_core_rstn", o_core_rstn, 0);
    chk("rst_done", o_done, 0);
    chk("rst_flags", {o_pass, o_fail, o_timeout, o_halt}, 0);
    chk("rst_exit", o_exit_code, 0);
    chk("rst_cnt", o_cycle_cnt, 0);
    @(negedge i_clk);
    i_rstn = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      chk($sformatf("hold_edge%0d", i), o_core_rstn, (i == 4));
    end
    chk("run_start_cnt", o_cycle_cnt, 0);
    chk("run_start_done", o_done, 0);
  endtask

  initial begin
    // Pass, with a tohost write present during reset hold that must be ignored.
    bus(1, 32'hF00, 32'd1, 4'hF);
    do_reset();
    bus(0, 0, 0, 0);
    repeat (20) step();
    chk("pre_pass_cnt", o_cycle_cnt, 20);
    chk("pre_pass_done", o_done, 0);
    bus(1, 32'hF00, 32'd1, 4'hF);
    step();
    chk("pass_flag", o_pass, 1);
    chk("pass_done", o_done, 1);
    chk("pass_others", {o_fail, o_timeout, o_halt}, 0);
    chk("pass_cnt", o_cycle_cnt, 21);
    bus(1, 32'hF00, 32'd7, 4'hF);
    step();
    bus(0, 0, 0, 0);
    repeat (3) step();
    chk("pass_sticky", o_pass, 1);
    chk("pass_no_fail", o_fail, 0);
    chk("pass_exit", o_exit_code, 0);
    chk("pass_frozen", o_cycle_cnt, 21);

    // Fail, with even and partial/misaddressed writes filtered out.
    do_reset();
    repeat (5) step();
    bus(1, 32'hF00, 32'd6, 4'hF);
    step();
    chk("even_ignored", o_done, 0);
    bus(1, 32'hF00, 32'd1, 4'b0011);
    step();
    chk("partial_ignored", o_done, 0);
    bus(1, 32'hF04, 32'd1, 4'hF);
    step();
    chk("addr_ignored", o_done, 0);
    chk("filter_cnt", o_cycle_cnt, 8);
    bus(1, 32'hF00, 32'd7, 4'hF);
    step();
    bus(0, 0, 0, 0);
    chk("fail_flag", o_fail, 1);
    chk("fail_exit", o_exit_code, 3);
    chk("fail_done", o_done, 1);
    chk("fail_no_pass", o_pass, 0);
    chk("fail_cnt", o_cycle_cnt, 9);

    // Timeout.
    do_reset();
    repeat (99) step();
    chk("pre_to_cnt", o_cycle_cnt, 99);
    chk("pre_to_done", o_done, 0);
    step();
    chk("to_flag", o_timeout, 1);
    chk("to_done", o_done, 1);
    chk("to_cnt", o_cycle_cnt, 100);
    repeat (5) step();
    chk("to_sticky", o_timeout, 1);
    chk("to_frozen", o_cycle_cnt, 100);

    // Tohost hit in the timeout cycle wins.
    do_reset();
    repeat (99) step();
    bus(1, 32'hF00, 32'd1, 4'hF);
    step();
    bus(0, 0, 0, 0);
    chk("prio_pass", o_pass, 1);
    chk("prio_no_to", o_timeout, 0);
    chk("prio_cnt", o_cycle_cnt, 100);

    // Stalled PC at 0x40.
    do_reset();
    hold_pc = 1'b1;
    i_pc = 32'h40;
    repeat (8) step();
    chk("pre_halt_done", o_done, 0);
    step();
`ifdef RISCV_TEST_CTRL_HALT_DET_EN
    chk("halt_flag", o_halt, 1);
    chk("halt_done", o_done, 1);
    chk("halt_cnt", o_cycle_cnt, 9);
`else
    chk("nohalt_flag", o_halt, 0);
    chk("nohalt_done", o_done, 0);
    repeat (91) step();
    chk("nohalt_to", o_timeout, 1);
    chk("nohalt_halt", o_halt, 0);
    chk("nohalt_cnt", o_cycle_cnt, 100);
`endif
    hold_pc = 1'b0;

    // Abort mid-RUN and restart.
    do_reset();
    repeat (50) step();
    chk("abort_pre_cnt", o_cycle_cnt, 50);
    do_reset();
    repeat (3) step();
    chk("abort_restart_cnt", o_cycle_cnt, 3);
    chk("abort_restart_done", o_done, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
